// File: rtl/serial_operand_rx_pkg.sv
// Shared definitions for the serial operand receiver of the adder demo.
//   DATA_W_DEF : default operand width
//   FRAME_LEN  : bits per frame (two operands)
//   rx_state_t : receiver FSM states
package cda_demo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int FRAME_LEN  = 2 * DATA_W_DEF;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchronizer: STAGES flops in series, all reset to RST_VAL.
//   clk : system clock
//   rst : synchronous active-high reset
//   d   : asynchronous input
//   q   : synchronized output (last flop of the chain)
module bit_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) ff <= {STAGES{RST_VAL}};
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/serial_operand_rx.sv
// Receives two DATA_W-bit operands over a 3-wire SPI-style link
// (s_csn / s_sck / s_sdi, MSB first) oversampled by clk.
//   clk, rst          : system clock, synchronous active-high reset
//   s_csn/s_sck/s_sdi : asynchronous serial link pins
//   op_a, op_b        : operand pair, held between frames
//   op_valid          : one-cycle pulse when op_a/op_b are updated
//   frame_err         : one-cycle pulse when a frame had the wrong bit count
//   busy              : high while a frame is being shifted in
module serial_operand_rx
    import cda_demo_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_csn,
    input  logic              s_sck,
    input  logic              s_sdi,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int         FRAME_BITS = 2 * DATA_W;
    localparam int         CNT_W      = $clog2(FRAME_BITS + 1);
    // Cycles after reset before the csn edge register reflects the pin;
    // until then the synchronizer still holds its reset value.
    localparam logic [2:0] ARM_SETTLE = 3'(SYNC_STAGES + 1);

    logic csn_s, sck_s, sdi_s;
    logic csn_d, sck_d, sdi_d;
    logic sck_rise, csn_fall, csn_rise;

    rx_state_t state, state_nx;

    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf;
    logic [2:0]            arm_cnt;

    // ---------------- synchronizers ----------------
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rst(rst), .d(s_csn), .q(csn_s));
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(s_sck), .q(sck_s));
    bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst(rst), .d(s_sdi), .q(sdi_s));

    // ---------------- edge detection ----------------
    // Strobes are registered; sdi_d is delayed by the same stage so the
    // data bit lines up with its sck_rise strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            csn_d    <= 1'b1;
            sck_d    <= 1'b0;
            sdi_d    <= 1'b0;
            sck_rise <= 1'b0;
            csn_fall <= 1'b0;
            csn_rise <= 1'b0;
        end else begin
            csn_d    <= csn_s;
            sck_d    <= sck_s;
            sdi_d    <= sdi_s;
            sck_rise <= sck_s & ~sck_d;
            csn_fall <= ~csn_s & csn_d;
            csn_rise <= csn_s & ~csn_d;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= ARM;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ARM:     if (arm_cnt == ARM_SETTLE && csn_d) state_nx = IDLE;
            IDLE:    if (csn_fall) state_nx = SHIFT;
            SHIFT:   if (csn_rise) state_nx = IDLE;
            default: state_nx = ARM;
        endcase
    end

    // ---------------- datapath and outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            arm_cnt   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            op_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= (state_nx == SHIFT);

            if (state == ARM && arm_cnt != ARM_SETTLE) arm_cnt <= arm_cnt + 3'd1;

            case (state)
                IDLE: begin
                    if (csn_fall) begin
                        shift_q <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                    end
                end
                SHIFT: begin
                    // csn_rise takes priority over a coincident sck edge
                    if (csn_rise) begin
                        if (cnt == CNT_W'(FRAME_BITS) && !ovf) begin
                            op_a     <= shift_q[FRAME_BITS-1:DATA_W];
                            op_b     <= shift_q[DATA_W-1:0];
                            op_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sck_rise) begin
                        if (cnt == CNT_W'(FRAME_BITS)) begin
                            ovf <= 1'b1;
                        end else begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], sdi_d};
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_operand_rx.sv
module tb_serial_operand_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_csn = 1'b1;
    logic       s_sck = 1'b0;
    logic       s_sdi = 1'b0;
    logic [7:0] op_a, op_b;
    logic       op_valid, frame_err, busy;

    int checks = 0;
    int failures = 0;

    // pulse monitors (only ever incremented here; tests take snapshots)
    int  vcnt = 0, ecnt = 0, busy_cyc = 0;
    logic both_hi = 1'b0;

    serial_operand_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .s_csn(s_csn), .s_sck(s_sck), .s_sdi(s_sdi),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_valid) vcnt++;
        if (frame_err) ecnt++;
        if (busy) busy_cyc++;
        if (op_valid && frame_err) both_hi = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sck_bit(input logic b);
        s_sdi = b;
        repeat (2) @(negedge clk);
        s_sck = 1'b1;
        repeat (4) @(negedge clk);
        s_sck = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) sck_bit(v[i]);
    endtask

    task automatic frame_start();
        s_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        s_csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    int v0, e0, b0;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // reset state
        chk("rst_op_a", op_a, 8'h00);
        chk("rst_op_b", op_b, 8'h00);
        chk("rst_valid", op_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // frame A5,3C with latency check on the closing csn edge
        v0 = vcnt; e0 = ecnt;
        frame_start();
        chk("busy_in_frame", busy, 1'b1);
        send_bits(32'hA53C, 16);
        s_csn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("lat_valid_early", op_valid, 1'b0);
        @(posedge clk);
        #1 chk("lat_valid_edge4", op_valid, 1'b1);
        chk("busy_fall_with_valid", busy, 1'b0);
        repeat (6) @(negedge clk);
        chk("f1_vcnt", vcnt - v0, 1);
        chk("f1_ecnt", ecnt - e0, 0);
        chk("f1_op_a", op_a, 8'hA5);
        chk("f1_op_b", op_b, 8'h3C);
        chk("f1_busy", busy, 1'b0);

        // 15-bit frame, then 17-bit frame
        v0 = vcnt; e0 = ecnt;
        frame_start();
        send_bits(32'h1234, 15);
        frame_end();
        chk("short_ecnt", ecnt - e0, 1);
        frame_start();
        send_bits(32'h1FFFF, 17);
        frame_end();
        chk("long_ecnt", ecnt - e0, 2);
        chk("badlen_vcnt", vcnt - v0, 0);
        chk("badlen_op_a", op_a, 8'hA5);
        chk("badlen_op_b", op_b, 8'h3C);

        // back-to-back frames, minimum csn gap
        v0 = vcnt; e0 = ecnt;
        frame_start();
        send_bits(32'hFF01, 16);
        s_csn = 1'b1;
        repeat (3) @(negedge clk);
        s_csn = 1'b0;
        @(posedge clk);
        #1 chk("b2b_op_a1", op_a, 8'hFF);
        chk("b2b_op_b1", op_b, 8'h01);
        repeat (4) @(negedge clk);
        send_bits(32'h0000, 16);
        frame_end();
        chk("b2b_vcnt", vcnt - v0, 2);
        chk("b2b_ecnt", ecnt - e0, 0);
        chk("b2b_op_a2", op_a, 8'h00);
        chk("b2b_op_b2", op_b, 8'h00);

        // reset mid-frame
        frame_start();
        send_bits(32'h12, 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v0 = vcnt; e0 = ecnt; b0 = busy_cyc;
        send_bits(32'h34, 8);
        frame_end();
        chk("rstmid_vcnt", vcnt - v0, 0);
        chk("rstmid_ecnt", ecnt - e0, 0);
        chk("rstmid_busy", busy_cyc - b0, 0);
        frame_start();
        send_bits(32'h1234, 16);
        frame_end();
        chk("rstmid_next_vcnt", vcnt - v0, 1);
        chk("rstmid_op_a", op_a, 8'h12);
        chk("rstmid_op_b", op_b, 8'h34);

        // csn_rise coincident with 16th sck rise
        v0 = vcnt; e0 = ecnt;
        frame_start();
        send_bits(32'h5555, 15);
        s_sdi = 1'b1;
        repeat (2) @(negedge clk);
        s_sck = 1'b1;
        s_csn = 1'b1;
        repeat (4) @(negedge clk);
        s_sck = 1'b0;
        repeat (8) @(negedge clk);
        chk("coinc_ecnt", ecnt - e0, 1);
        chk("coinc_vcnt", vcnt - v0, 0);
        chk("coinc_op_a", op_a, 8'h12);

        // zero-bit frame
        v0 = vcnt; e0 = ecnt; b0 = busy_cyc;
        s_csn = 1'b0;
        repeat (10) @(negedge clk);
        s_csn = 1'b1;
        repeat (8) @(negedge clk);
        chk("zero_ecnt", ecnt - e0, 1);
        chk("zero_vcnt", vcnt - v0, 0);
        chk("zero_busy_cycles", busy_cyc - b0, 10);

        chk("never_both_pulses", both_hi, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_operand_rx.md
# serial_operand_rx

Serial receiver that loads the two 8-bit adder operands from a 3-wire, SPI-style link (chip-select, serial clock, data) driven by an external controller. It produces the parallel operands that the demo adder consumes. It sits between the dedicated input pins and the adder's operand inputs. It oversamples the link with the system clock, frames 16-bit transfers, and presents a validated operand pair with a one-cycle strobe.

## Interface
- `DATA_W`, default 8: width of each operand; frame length is 2*DATA_W bits.
- `SYNC_STAGES`, default 2: synchronizer depth on each serial input; legal values are 2 or 3.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `s_csn`, in, 1: frame select, active low, asynchronous to `clk`.
- `s_sck`, in, 1: serial clock, asynchronous; data is sampled on its rising edge.
- `s_sdi`, in, 1: serial data, MSB first, asynchronous.
- `op_a`, out, DATA_W: operand A, the first DATA_W bits of the frame.
- `op_b`, out, DATA_W: operand B, the last DATA_W bits of the frame.
- `op_valid`, out, 1: one-cycle pulse when `op_a`/`op_b` are updated.
- `frame_err`, out, 1: one-cycle pulse when a frame ends with the wrong bit count.
- `busy`, out, 1: high while a frame is in progress (state SHIFT).

## Operation
- All three inputs pass through SYNC_STAGES flops.
- Synchronizer reset values: `s_csn` = 1, `s_sck` = 0, `s_sdi` = 0.
- One extra register per signal provides edge detection:
  - `sck_rise`: the synchronized `s_sck` goes 0 to 1.
  - `csn_fall` and `csn_rise`: the synchronized `s_csn` goes 1 to 0 and 0 to 1.
- States:
  - ARM: reset state. Go to IDLE once the synchronized `s_csn` = 1. This discards any frame that was already open when reset was released.
  - IDLE: on `csn_fall`, go to SHIFT and clear the 16-bit shift register, the 5-bit bit counter and the overflow flag.
  - SHIFT, on `sck_rise`: shift the register left with the synchronized `s_sdi` entering at the LSB, and increment the counter.
  - SHIFT, when the counter is already 2*DATA_W: a further `sck_rise` does not shift. It sets the overflow flag instead.
  - SHIFT, on `csn_rise`: go to IDLE. If counter = 2*DATA_W and no overflow, load `op_a` = shift[15:8] and `op_b` = shift[7:0] and pulse `op_valid`. Otherwise pulse `frame_err`, and `op_a`/`op_b` keep their previous values.
- If `sck_rise` and `csn_rise` happen in the same cycle, `csn_rise` wins and the sck edge is ignored.
- A zero-bit frame (`s_csn` low then high with no sck) is an error and pulses `frame_err`.
- `op_a`/`op_b` hold their value between frames. The adder sees stable operands at all times.
- Reset mid-frame: every register returns to its reset value on the next `clk` edge, the partial frame is lost, and the state goes to ARM.
- Output reset values: `op_a` = 0, `op_b` = 0, `op_valid` = 0, `frame_err` = 0, `busy` = 0.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Pin-to-detect latency is SYNC_STAGES+1 `clk` edges.
- `op_valid`/`frame_err` assert on the clk edge after `csn_rise` is detected. With the defaults, that is 4 `clk` edges after the pin change is first sampled.
- `op_valid` and `frame_err` are exactly one cycle wide and are never high together.
- `busy` rises with entry into SHIFT and falls in the same cycle that `op_valid`/`frame_err` rises.
- Link constraints:
  - `s_sck` high time ≥ 3 clk periods and low time ≥ 3 clk periods.
  - `s_sdi` stable from 1 clk period before to 3 clk periods after the `s_sck` rise.
  - `s_csn` high time between frames ≥ 3 clk periods.
- Back-to-back frames are supported. The next `csn_fall` may be detected in the cycle after `op_valid`.

## Structure
- Package `cda_demo_pkg` holds:
  - `DATA_W_DEF` = 8 and `FRAME_LEN` = 2*DATA_W_DEF.
  - The state enum `rx_state_t` {ARM, IDLE, SHIFT}.
- Sub-module `bit_sync`: a parameterized SYNC_STAGES flop chain with a reset value parameter. It is instantiated three times.
- The top level holds the edge detectors, the FSM, the shift register, the counter and the output registers. Target size is about 150–200 lines.

## Test plan
- Reset, then frame 0xA5,0x3C (16 sck pulses, csn high) → `op_valid` pulses once with `op_a` = 0xA5 and `op_b` = 0x3C. `busy` is low afterwards and `frame_err` stays 0.
- Frame of 15 bits, then a frame of 17 bits → `frame_err` pulses once for each frame. `op_a`/`op_b` keep the prior values 0xA5/0x3C and `op_valid` never asserts.
- Two back-to-back frames 0xFF,0x01 then 0x00,0x00 with minimum csn gap → two `op_valid` pulses, and the operands are FF/01 then 00/00.
- Assert `rst` for 1 cycle after 8 bits of a frame while csn stays low, then finish the frame → no `op_valid` and no `frame_err`. The block stays in ARM until csn goes high, and the next full frame 0x12,0x34 is accepted.
- `csn_rise` coincident with the 16th `sck_rise` → only 15 bits are counted, so `frame_err` pulses and `op_valid` stays 0.
- Zero-bit frame (csn low for 10 cycles, no sck) → `frame_err` pulses once and `busy` was high for the duration.
